// File: rtl/parity_acc_ctrl.sv
// Parity accumulator bank controller for the parallel RCE encoder.
// Accumulates NB LM-bit slices using XOR (GF(2)) per codeword, then offers
// the parity word over a valid/ready handshake.
// Optional feature macro: PACC_ABORT_EN adds an abort input that returns the
// controller to IDLE from ACC or DONE.
module parity_acc_ctrl #(
  parameter int LM    = 16,
  parameter int NB    = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LM-1:0]    w_in,
  input  logic             w_valid,
  output logic             w_ready,
  output logic             busy,
  output logic [CNT_W-1:0] col_idx,
  output logic [LM-1:0]    p_out,
  output logic             p_valid,
  input  logic             p_ready
`ifdef PACC_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NB - 1);

  state_t           state_q, state_d;
  logic [LM-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             abort_w;

`ifdef PACC_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // GF(2) addition: bitwise XOR, no carries between bit positions.
  function automatic logic [LM-1:0] gf2_add(input logic [LM-1:0] a,
                                            input logic [LM-1:0] b);
    return a ^ b;
  endfunction

  // State, accumulator and column counter registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      col_q   <= col_d;
    end
  end

  // Next-state and accumulator/counter update; abort outranks beats, handshakes and start.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    col_d   = col_q;
    if (abort_w && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      acc_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ACC;
            acc_d   = '0;
            col_d   = '0;
          end
        end
        S_ACC: begin
          // Bubbles (w_valid low) hold everything; start is ignored here.
          if (w_valid) begin
            acc_d = gf2_add(acc_q, w_in);
            if (col_q == LAST_COL) begin
              state_d = S_DONE;
              col_d   = '0;
            end else begin
              col_d = col_q + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          // acc is retained on return to IDLE so p_out keeps its last value.
          if (p_ready) begin
            if (start) begin
              state_d = S_ACC;
              acc_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
          col_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode from registers only, with no input-to-output paths.
  always_comb begin
    w_ready = (state_q == S_ACC);
    busy    = (state_q == S_ACC) || (state_q == S_DONE);
    p_valid = (state_q == S_DONE);
    col_idx = col_q;
    p_out   = acc_q;
  end

endmodule

// File: tb/tb_parity_acc_ctrl.sv
// Directed testbench for parity_acc_ctrl (LM=16, NB=4).
// Define PACC_ABORT_EN for both files to also exercise the abort path.
module tb_parity_acc_ctrl;

  localparam int LM    = 16;
  localparam int NB    = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LM-1:0]    w_in;
  logic             w_valid;
  logic             w_ready;
  logic             busy;
  logic [CNT_W-1:0] col_idx;
  logic [LM-1:0]    p_out;
  logic             p_valid;
  logic             p_ready;
`ifdef PACC_ABORT_EN
  logic             abort;
`endif

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int c0, c1;

  parity_acc_ctrl #(.LM(LM), .NB(NB), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .w_in    (w_in),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .busy    (busy),
    .col_idx (col_idx),
    .p_out   (p_out),
    .p_valid (p_valid),
    .p_ready (p_ready)
`ifdef PACC_ABORT_EN
    ,
    .abort   (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [LM-1:0] v);
    w_in    = v;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    w_in    = 16'hDEAD;
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    w_in    = '0;
    w_valid = 1'b0;
    p_ready = 1'b0;
`ifdef PACC_ABORT_EN
    abort   = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    check("rst_w_ready", w_ready, 0);
    check("rst_busy",    busy,    0);
    check("rst_p_valid", p_valid, 0);
    check("rst_col",     col_idx, 0);
    check("rst_p_out",   p_out,   0);
    rst = 1'b1;
    tick();
    check("idle_w_ready", w_ready, 0);

    // Basic accumulation
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_w_ready", w_ready, 1);
    check("start_busy",    busy,    1);
    check("start_col",     col_idx, 0);
    beat(16'h0001); check("basic_col1", col_idx, 1);
    beat(16'h0003); check("basic_col2", col_idx, 2);
    beat(16'h00F0); check("basic_col3", col_idx, 3);
    check("basic_pv_early", p_valid, 0);
    beat(16'h8000);
    check("basic_col_wrap", col_idx, 0);
    check("basic_p_valid",  p_valid, 1);
    check("basic_w_ready",  w_ready, 0);
    check("basic_p_out",    p_out,   16'h80F2);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    check("hs_p_valid", p_valid, 0);
    check("hs_busy",    busy,    0);
    check("hs_p_out",   p_out,   16'h80F2);

    // Bubbles and backpressure
    start = 1'b1;
    tick();
    start = 1'b0;
    beat(16'h0001);
    w_in = 16'hFFFF; tick(); tick();
    check("bub_col1", col_idx, 1);
    beat(16'h0003);
    w_in = 16'hFFFF; tick(); tick();
    check("bub_col2", col_idx, 2);
    beat(16'h00F0);
    w_in = 16'hFFFF; tick(); tick();
    check("bub_col3", col_idx, 3);
    beat(16'h8000);
    w_valid = 1'b1;
    w_in    = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_p_valid", p_valid, 1);
      check("bp_p_out",   p_out,   16'h80F2);
    end
    w_valid = 1'b0;

    // Back-to-back: handshake with start, then four 16'hFFFF beats
    p_ready = 1'b1;
    start   = 1'b1;
    tick();
    c0 = cyc;
    check("b2b_w_ready", w_ready, 1);
    check("b2b_p_valid", p_valid, 0);
    check("b2b_acc_clr", p_out,   0);
    beat(16'hFFFF); beat(16'hFFFF); beat(16'hFFFF);
    check("b2b_col3", col_idx, 3);
    beat(16'hFFFF);
    check("b2b_p_valid2", p_valid, 1);
    check("b2b_p_out",    p_out,   16'h0000);
    tick();
    c1 = cyc;
    check("b2b_period", c1 - c0, 5);
    check("b2b_restart", w_ready, 1);
    start   = 1'b0;
    p_ready = 1'b0;

    // Reset in the middle of ACC
    beat(16'h1111);
    beat(16'h2222);
    check("mid_col2", col_idx, 2);
    rst = 1'b0;
    #2;
    check("mid_rst_p_valid", p_valid, 0);
    check("mid_rst_col",     col_idx, 0);
    check("mid_rst_w_ready", w_ready, 0);
    check("mid_rst_p_out",   p_out,   0);
    #1;
    rst = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) beat(16'h1234);
    check("post_rst_p_valid", p_valid, 1);
    check("post_rst_p_out",   p_out,   16'h0000);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    check("post_rst_idle", busy, 0);

`ifdef PACC_ABORT_EN
    // Abort together with the third beat
    start = 1'b1;
    tick();
    start = 1'b0;
    beat(16'h0F0F);
    beat(16'hF000);
    abort = 1'b1;
    beat(16'h00AA);
    abort = 1'b0;
    check("abort_busy",  busy,    0);
    check("abort_acc",   p_out,   0);
    check("abort_col",   col_idx, 0);
    check("abort_pv",    p_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    beat(16'h00FF); beat(16'h0000); beat(16'h0000); beat(16'h0000);
    check("abort_next_pv",    p_valid, 1);
    check("abort_next_p_out", p_out,   16'h00FF);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
